// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding, protocol constants and request payload shared by i2c_regacc.
`timescale 1ns/1ps
package i2c_pkg;

  localparam int unsigned TMO_W  = 24;
  localparam int unsigned DEV_W  = 7;
  localparam int unsigned BYTE_W = 8;

  localparam logic              I2C_RD_BIT    = 1'b1;
  localparam logic              I2C_WR_BIT    = 1'b0;
  localparam logic [BYTE_W-1:0] I2C_READ_FILL = 8'hff;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEVW,
    ST_REGA,
    ST_WDATA,
    ST_RESTART,
    ST_DEVR,
    ST_RDATA,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic              we;
    logic [DEV_W-1:0]  dev;
    logic [BYTE_W-1:0] regad;
    logic [BYTE_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/i2c_regacc.sv
// i2c_regacc: register read/write sequencer driving a byte-level I2C master.
// Optional per-byte ack timeout enabled by defining I2C_REGACC_TIMEOUT_EN.
`timescale 1ns/1ps
module i2c_regacc
  import i2c_pkg::*;
#(
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [DEV_W-1:0]  i_req_dev,
  input  logic [BYTE_W-1:0] i_req_reg,
  input  logic [BYTE_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic              o_rsp_err,
  output logic [BYTE_W-1:0] o_rsp_rdata,
  output logic              o_i2c_cyc,
  output logic              o_i2c_stb,
  output logic              o_i2c_we,
  output logic [BYTE_W-1:0] o_i2c_data,
  input  logic              i_i2c_ack,
  input  logic              i_i2c_busy,
  input  logic              i_i2c_err,
  input  logic [BYTE_W-1:0] i_i2c_data
);

  state_e            r_state;
  state_e            w_state_nxt;
  req_t              r_req;
  req_t              w_req_nxt;
  logic              w_req_ready_nxt;
  logic              w_rsp_valid_nxt;
  logic              w_rsp_err_nxt;
  logic [BYTE_W-1:0] w_rsp_rdata_nxt;
  logic              w_cyc_nxt;
  logic              w_stb_nxt;
  logic              w_we_nxt;
  logic [BYTE_W-1:0] w_data_nxt;
  logic              w_tmo_hit;

`ifdef I2C_REGACC_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo;
  logic             w_tmo_run;

  // Busy only holds off the count on the first byte of a transaction.
  assign w_tmo_run = o_i2c_stb && !((r_state == ST_DEVW) && i_i2c_busy);
  assign w_tmo_hit = w_tmo_run && (r_tmo >= (TIMEOUT_CYCLES - TMO_W'(1)));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tmo <= '0;
    end else if (w_state_nxt != r_state) begin
      r_tmo <= '0;
    end else if (w_tmo_run) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end
`else
  logic w_unused;

  assign w_tmo_hit = 1'b0;
  assign w_unused  = ^{i_i2c_busy, TIMEOUT_CYCLES};
`endif

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      o_req_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= '0;
      o_i2c_cyc   <= 1'b0;
      o_i2c_stb   <= 1'b0;
      o_i2c_we    <= 1'b0;
      o_i2c_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      o_req_ready <= w_req_ready_nxt;
      o_rsp_valid <= w_rsp_valid_nxt;
      o_rsp_err   <= w_rsp_err_nxt;
      o_rsp_rdata <= w_rsp_rdata_nxt;
      o_i2c_cyc   <= w_cyc_nxt;
      o_i2c_stb   <= w_stb_nxt;
      o_i2c_we    <= w_we_nxt;
      o_i2c_data  <= w_data_nxt;
    end
  end

  // Next state and next output values; bus outputs hold unless a transition changes them.
  always_comb begin
    w_state_nxt     = r_state;
    w_req_nxt       = r_req;
    w_req_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = o_rsp_rdata;
    w_cyc_nxt       = o_i2c_cyc;
    w_stb_nxt       = o_i2c_stb;
    w_we_nxt        = o_i2c_we;
    w_data_nxt      = o_i2c_data;

    unique case (r_state)
      ST_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (i_req_valid && o_req_ready) begin
          w_req_nxt       = '{we: i_req_we, dev: i_req_dev, regad: i_req_reg, wdata: i_req_wdata};
          w_req_ready_nxt = 1'b0;
          w_state_nxt     = ST_DEVW;
          w_cyc_nxt       = 1'b1;
          w_stb_nxt       = 1'b1;
          w_we_nxt        = 1'b1;
          w_data_nxt      = {i_req_dev, I2C_WR_BIT};
        end
      end

      ST_RESTART: begin
        w_state_nxt = ST_DEVR;
        w_cyc_nxt   = 1'b1;
        w_stb_nxt   = 1'b1;
        w_we_nxt    = 1'b1;
        w_data_nxt  = {r_req.dev, I2C_RD_BIT};
      end

      ST_RESP: begin
        w_state_nxt     = ST_IDLE;
        w_req_ready_nxt = 1'b1;
      end

      default: begin
        if ((i_i2c_ack && i_i2c_err) || w_tmo_hit) begin
          w_state_nxt     = ST_RESP;
          w_cyc_nxt       = 1'b0;
          w_stb_nxt       = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
        end else if (i_i2c_ack) begin
          case (r_state)
            ST_DEVW: begin
              w_state_nxt = ST_REGA;
              w_we_nxt    = 1'b1;
              w_data_nxt  = r_req.regad;
            end
            ST_REGA: begin
              if (r_req.we) begin
                w_state_nxt = ST_WDATA;
                w_we_nxt    = 1'b1;
                w_data_nxt  = r_req.wdata;
              end else begin
                w_state_nxt = ST_RESTART;
                w_cyc_nxt   = 1'b0;
                w_stb_nxt   = 1'b0;
              end
            end
            ST_DEVR: begin
              w_state_nxt = ST_RDATA;
              w_we_nxt    = 1'b0;
              w_data_nxt  = I2C_READ_FILL;
            end
            ST_WDATA, ST_RDATA: begin
              if (r_state == ST_RDATA) begin
                w_rsp_rdata_nxt = i_i2c_data;
              end
              w_state_nxt     = ST_RESP;
              w_cyc_nxt       = 1'b0;
              w_stb_nxt       = 1'b0;
              w_rsp_valid_nxt = 1'b1;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_regacc.sv
// tb_i2c_regacc: randomized self-checking bench; a byte-engine responder plus a
// transaction-level model of the expected byte stream and response.
`timescale 1ns/1ps
module tb_i2c_regacc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid, req_ready, req_we;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       cyc, stb, iwe;
  logic [7:0] idata;
  logic       ack, busy, ierr;
  logic [7:0] ird;

  always #5 clk = ~clk;

  i2c_regacc #(.TIMEOUT_CYCLES(24'd100)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_dev(req_dev), .i_req_reg(req_reg), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rsp_rdata(rsp_rdata),
    .o_i2c_cyc(cyc), .o_i2c_stb(stb), .o_i2c_we(iwe), .o_i2c_data(idata),
    .i_i2c_ack(ack), .i_i2c_busy(busy), .i_i2c_err(ierr), .i_i2c_data(ird)
  );

  int         n_tests = 0;
  int         n_fail = 0;
  int         eng_mode = 0;   // 0 silent, 1 normal responder, 2 ack forced high
  int         err_at = 99;
  int         byte_idx = 0;
  int         dly = 0;
  int         max_dly = 3;
  bit         busy_en = 1'b1;
  logic [7:0] rd_val = 8'h00;
  logic [7:0] exp_rdata = 8'h00;
  logic [8:0] log_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte-engine responder: acks each strobed byte after a random delay, logs {we,data}.
  initial begin
    ack = 1'b0; ierr = 1'b0; ird = 8'h00; busy = 1'b0;
    forever begin
      @(negedge clk);
      busy = busy_en && ($urandom_range(0, 3) == 0);
      if (eng_mode == 2) begin
        ack = 1'b1; ierr = 1'b0;
      end else if (ack) begin
        ack = 1'b0; ierr = 1'b0; dly = $urandom_range(0, max_dly);
      end else if (eng_mode == 1 && stb) begin
        if (dly == 0) begin
          log_q.push_back({iwe, idata});
          ack  = 1'b1;
          ierr = (byte_idx == err_at);
          ird  = iwe ? 8'($urandom) : rd_val;
          byte_idx++;
        end else begin
          dly--;
        end
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input logic we, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd);
    req_valid = 1'b1; req_we = we; req_dev = dev; req_reg = rg; req_wdata = wd;
  endtask

  task automatic wait_accept();
    int cnt = 0;
    while (!req_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("req_ready_seen", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_txn(input logic we, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd, input logic [7:0] rv, input int ea);
    logic [8:0] exp_q[$];
    bit exp_err, got;
    int gaps, stb_gaps, rdy_hi;
    exp_q = {};
    exp_q.push_back({1'b1, dev, 1'b0});
    exp_q.push_back({1'b1, rg});
    if (we) exp_q.push_back({1'b1, wd});
    else begin
      exp_q.push_back({1'b1, dev, 1'b1});
      exp_q.push_back({1'b0, 8'hFF});
    end
    exp_err = (ea < exp_q.size());
    while (exp_q.size() > ea + 1) void'(exp_q.pop_back());
    if (!we && !exp_err) exp_rdata = rv;

    log_q.delete(); byte_idx = 0; err_at = ea; rd_val = rv;
    @(negedge clk);
    drive_req(we, dev, rg, wd);
    wait_accept();
    check("cyc_stb_after_accept", 32'({cyc, stb}), 32'b11);
    gaps = 0; stb_gaps = 0; rdy_hi = 0; got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rsp_valid) begin got = 1'b1; break; end
      if (!cyc) gaps++;
      else if (!stb) stb_gaps++;
      if (req_ready) rdy_hi++;
      @(negedge clk);
    end
    check("rsp_seen", 32'(got), 32'd1);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    check("cyc_gap", 32'(gaps), (!we && ea >= 2) ? 32'd1 : 32'd0);
    check("stb_gap", 32'(stb_gaps), 32'd0);
    check("ready_in_txn", 32'(rdy_hi), 32'd0);
    check("byte_count", 32'(log_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) if (i < log_q.size()) check("byte", 32'(log_q[i]), 32'(exp_q[i]));
    @(negedge clk);
    check("rsp_pulse_end", 32'({rsp_valid, req_ready}), 32'b01);
  endtask

  initial begin
    int cnt, acc, rsps, bad, pulses;
    bit outst;
    logic rw;
    int ea;
    req_valid = 1'b0; req_we = 1'b0; req_dev = '0; req_reg = '0; req_wdata = '0;
    #1;
    check("rst_outputs", 32'({req_ready, rsp_valid, rsp_err, cyc, stb, iwe}), 32'd0);
    check("rst_data", 32'({idata, rsp_rdata}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);
    eng_mode = 1;

    do_txn(1'b1, 7'h50, 8'h10, 8'hA5, 8'h00, 99);
    do_txn(1'b0, 7'h50, 8'h20, 8'h00, 8'h3C, 99);
    do_txn(1'b1, 7'h50, 8'h10, 8'h5A, 8'h00, 1);

    // Acks outside a byte state must be ignored.
    eng_mode = 2;
    repeat (3) begin
      @(negedge clk); #1;
      check("idle_ack_ignored", 32'({req_ready, cyc, stb, rsp_valid}), 32'b1000);
    end
    eng_mode = 1;
    repeat (2) @(negedge clk);
    check("idle_after_ack", 32'({req_ready, cyc, ack}), 32'b100);

    for (int t = 0; t < 12; t++) begin
      rw = 1'($urandom_range(0, 1));
      ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 99;
      do_txn(rw, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), ea);
    end

    // Back-to-back requests with valid held high.
    err_at = 99; byte_idx = 0; log_q.delete();
    acc = 0; rsps = 0; bad = 0; outst = 1'b0;
    @(negedge clk);
    drive_req(1'b1, 7'h11, 8'h22, 8'h33);
    for (int i = 0; i < 300 && rsps < 2; i++) begin
      if (rsp_valid) begin outst = 1'b0; rsps++; end
      else if (req_ready) begin
        if (outst) bad++;
        outst = 1'b1; acc++;
      end
      if (rsps < 2) @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(acc), 32'd2);
    check("b2b_rsps", 32'(rsps), 32'd2);
    check("b2b_ready_overlap", 32'(bad), 32'd0);
    @(negedge clk);

    // Reset while the register-address byte is on the bus.
    max_dly = 6; err_at = 99; byte_idx = 0; log_q.delete();
    @(negedge clk);
    drive_req(1'b1, 7'h2A, 8'h33, 8'h77);
    wait_accept();
    cnt = 0;
    while (log_q.size() < 1 && cnt < 50) begin @(negedge clk); cnt++; end
    @(negedge clk);
    check("in_rega", 32'({cyc, stb, idata}), 32'({2'b11, 8'h33}));
    eng_mode = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 32'({req_ready, rsp_valid, rsp_err, cyc, stb, iwe}), 32'd0);
    check("async_rst_data", 32'({idata, rsp_rdata}), 32'd0);
    pulses = 0;
    repeat (2) begin @(negedge clk); if (rsp_valid) pulses++; end
    rst_n = 1'b1;
    @(negedge clk);
    if (rsp_valid) pulses++;
    check("rst_no_rsp", 32'(pulses), 32'd0);
    check("ready_after_rst2", 32'(req_ready), 32'd1);
    exp_rdata = 8'h00; max_dly = 3; eng_mode = 1;
    do_txn(1'b1, 7'h2A, 8'h33, 8'h77, 8'h00, 99);

`ifdef I2C_REGACC_TIMEOUT_EN
    // Ack withheld: the per-byte timeout must abort with an error.
    eng_mode = 0; busy_en = 1'b0;
    @(negedge clk);
    drive_req(1'b1, 7'h50, 8'h10, 8'hA5);
    wait_accept();
    cnt = 0;
    while (!rsp_valid && cnt < 300) begin @(negedge clk); cnt++; end
    check("tmo_in_window", 32'(cnt >= 98 && cnt <= 102), 32'd1);
    check("tmo_err", 32'(rsp_err), 32'd1);
    busy_en = 1'b1; eng_mode = 1;
    repeat (2) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
